temp_register_pipe: RTL and testbench
=====================================

TEMP_REGISTER_PIPE -- requirements
Module: temp_register_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits of every stage.
REQ-002 Parameter DEPTH, default 4, number of register stages; legal range 1..8.
REQ-003 Parameter CW, default 4, width of Count and RdSel; SHALL be at least clog2(DEPTH+1).
REQ-004 CLK  input  1  single clock; all state updates on the falling edge of CLK.
REQ-005 RST  input  1  reset, synchronous, active-low; sampled on the falling edge of CLK.
REQ-006 WE  input  1  write enable; marks DataIn as a valid entry for stage 0.
REQ-007 Stall  input  1  freezes all stages, data and valid bits.
REQ-008 Flush  input  1  invalidates and zeroes all stages.
REQ-009 DataIn  input  WIDTH  data captured into stage 0.
REQ-010 RdSel  input  CW  stage index for the tap read port.
REQ-011 DataOut  output  WIDTH  data of stage DEPTH-1.
REQ-012 ValidOut  output  1  valid bit of stage DEPTH-1.
REQ-013 TapData  output  WIDTH  data of stage RdSel, combinational from stage registers.
REQ-014 TapValid  output  1  valid bit of stage RdSel.
REQ-015 Count  output  CW  number of stages currently holding valid data, registered.

Function
REQ-016 State per stage k (0..DEPTH-1): data register D[k] (WIDTH bits) and valid bit V[k].
REQ-017 Priority on each falling edge: RST low > Flush > Stall > Advance.
REQ-018 Flush: all D[k] to 0, all V[k] to 0, Count to 0; DataIn is not captured.
REQ-019 Stall (Flush low): all D[k], V[k], Count unchanged; WE and DataIn ignored.
REQ-020 Advance: D[k] <= D[k-1], V[k] <= V[k-1] for k=1..DEPTH-1; entry leaving stage DEPTH-1 is discarded.
REQ-021 Advance stage 0: WE=1 -> D[0] <= DataIn, V[0] <= 1; WE=0 -> D[0] <= 0, V[0] <= 0 (bubble).
REQ-022 Latency: a word written with WE=1 at edge n appears on DataOut/ValidOut after edge n+DEPTH-1, absent stalls; each Stall edge adds one edge of delay.
REQ-023 Count SHALL equal the number of set V[k] after every edge; updated as Count + V_in(stage 0) - V[DEPTH-1]_old on Advance, never exceeding DEPTH, never underflowing.
REQ-024 RdSel >= DEPTH: TapData SHALL be 0 and TapValid SHALL be 0.
REQ-025 DEPTH=1: D[0]/V[0] drive DataOut and ValidOut directly; behaviour SHALL otherwise match REQ-016..REQ-023 (a WE-held single temp register with valid flag).
REQ-026 Simultaneous WE and Flush: Flush wins, the word is lost; simultaneous WE and Stall: Stall wins, the word is lost.
REQ-027 No combinational path from DataIn, WE, Stall or Flush to any output; only RdSel feeds outputs combinationally.

Reset
REQ-028 RST low at a falling edge: all D[k]=0, all V[k]=0, Count=0; DataOut=0, ValidOut=0 after that edge.
REQ-029 RST low SHALL override Flush, Stall and WE; asserting RST mid-stream discards all in-flight entries.
REQ-030 First edge with RST high SHALL perform normal Flush/Stall/Advance processing.

Verification
REQ-031 DEPTH=4, reset, WE=1 with DataIn=0xA5A5A5A5 for one edge then WE=0 -> ValidOut=1, DataOut=0xA5A5A5A5 after edge 4 only; Count 1,1,1,1,0.
REQ-032 DEPTH=4, stream 0x1,0x2,0x3,0x4, Stall high on edge 3 -> DataOut 0x1 delayed by one edge; Count peaks at 4, never exceeds 4.
REQ-033 Pipeline full (Count=4), Flush and WE=1 same edge -> Count=0, ValidOut=0, all TapValid 0 for RdSel 0..3.
REQ-034 Pipeline full, RST low with Stall high -> all stages zero, Count=0; next edge WE=1 DataIn=0xDEAD -> TapData(RdSel=0)=0xDEAD, TapValid=1.
REQ-035 RdSel=5 with DEPTH=4 -> TapData=0, TapValid=0 regardless of contents.
REQ-036 DEPTH=1, WE=1 DataIn=0x12345678 -> DataOut=0x12345678, ValidOut=1 after one edge; WE=0 next edge -> ValidOut=0, DataOut=0.

Source files
------------

// File: rtl/temp_register_pipe.sv
// rtl/temp_register_pipe.sv - stallable, flushable register pipeline with valid bits, occupancy count and tap read port
module temp_register_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic             Stall,
  input  logic             Flush,
  input  logic [WIDTH-1:0] DataIn,
  input  logic [CW-1:0]    RdSel,
  output logic [WIDTH-1:0] DataOut,
  output logic             ValidOut,
  output logic [WIDTH-1:0] TapData,
  output logic             TapValid,
  output logic [CW-1:0]    Count
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [CW-1:0]    r_count;

  logic [WIDTH-1:0] w_tap_data;
  logic             w_tap_valid;

  // Stage state: reset beats flush beats stall beats advance; everything moves on the falling edge
  always_ff @(negedge CLK) begin
    if (!RST) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
      end
      r_valid <= '0;
      r_count <= '0;
    end else if (Flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
      end
      r_valid <= '0;
      r_count <= '0;
    end else if (!Stall) begin
      for (int k = 1; k < DEPTH; k++) begin
        r_data[k]  <= r_data[k-1];
        r_valid[k] <= r_valid[k-1];
      end
      // A cycle without WE injects a zeroed bubble so stage 0 never holds stale data
      r_data[0]  <= WE ? DataIn : '0;
      r_valid[0] <= WE;
      // Occupancy tracks one entry in, one entry out; both can happen in the same edge
      r_count    <= r_count + CW'(WE) - CW'(r_valid[DEPTH-1]);
    end
  end

  // Tap read mux: out-of-range selects read as an empty stage
  always_comb begin
    w_tap_data  = '0;
    w_tap_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (RdSel == CW'(k)) begin
        w_tap_data  = r_data[k];
        w_tap_valid = r_valid[k];
      end
    end
  end

  assign DataOut  = r_data[DEPTH-1];
  assign ValidOut = r_valid[DEPTH-1];
  assign TapData  = w_tap_data;
  assign TapValid = w_tap_valid;
  assign Count    = r_count;

endmodule

// File: tb/tb_temp_register_pipe.sv
// tb/tb_temp_register_pipe.sv - directed self-checking bench for temp_register_pipe (DEPTH=4 and DEPTH=1)
module tb_temp_register_pipe;

  logic        CLK;
  logic        RST;
  logic        WE;
  logic        Stall;
  logic        Flush;
  logic [31:0] DataIn;
  logic [3:0]  RdSel;
  logic [31:0] DataOut;
  logic        ValidOut;
  logic [31:0] TapData;
  logic        TapValid;
  logic [3:0]  Count;

  logic [0:0]  RdSel1;
  logic [31:0] DataOut1;
  logic        ValidOut1;
  logic [31:0] TapData1;
  logic        TapValid1;
  logic [0:0]  Count1;

  int n_checks = 0;
  int n_fails  = 0;

  temp_register_pipe #(.WIDTH(32), .DEPTH(4), .CW(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .WE(WE), .Stall(Stall), .Flush(Flush),
    .DataIn(DataIn), .RdSel(RdSel),
    .DataOut(DataOut), .ValidOut(ValidOut),
    .TapData(TapData), .TapValid(TapValid), .Count(Count)
  );

  temp_register_pipe #(.WIDTH(32), .DEPTH(1), .CW(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .WE(WE), .Stall(Stall), .Flush(Flush),
    .DataIn(DataIn), .RdSel(RdSel1),
    .DataOut(DataOut1), .ValidOut(ValidOut1),
    .TapData(TapData1), .TapValid(TapValid1), .Count(Count1)
  );

  initial CLK = 1'b1;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Active edge is falling; settle 1 time unit after it before driving or sampling
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  // Stream vector table: we, stall, din -> count, valid_out, data_out after the edge
  logic        s_we    [6] = '{1, 1, 1, 1, 1, 1};
  logic        s_stall [6] = '{0, 0, 1, 0, 0, 0};
  logic [31:0] s_din   [6] = '{32'h1, 32'h2, 32'h3, 32'h3, 32'h4, 32'h5};
  logic [3:0]  s_cnt   [6] = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd4};
  logic        s_vld   [6] = '{0, 0, 0, 0, 1, 1};
  logic [31:0] s_dout  [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h2};
  logic [31:0] tap_exp [4] = '{32'h5, 32'h4, 32'h3, 32'h2};

  // Single-word latency table for DEPTH=4
  logic [3:0]  l_cnt   [5] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0};
  logic        l_vld   [5] = '{0, 0, 0, 1, 0};
  logic [31:0] l_dout  [5] = '{32'h0, 32'h0, 32'h0, 32'hA5A5A5A5, 32'h0};

  initial begin
    RST = 1'b0; WE = 1'b0; Stall = 1'b0; Flush = 1'b0;
    DataIn = '0; RdSel = '0; RdSel1 = '0;

    // Reset state
    tick();
    check("rst_count", 64'(Count), 64'd0);
    check("rst_valid", 64'(ValidOut), 64'd0);
    check("rst_dout", 64'(DataOut), 64'd0);

    // Single word: visible on DataOut only after the fourth edge
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      WE = (i == 0);
      DataIn = (i == 0) ? 32'hA5A5A5A5 : 32'h0;
      tick();
      check($sformatf("lat_count_e%0d", i + 1), 64'(Count), 64'(l_cnt[i]));
      check($sformatf("lat_valid_e%0d", i + 1), 64'(ValidOut), 64'(l_vld[i]));
      check($sformatf("lat_dout_e%0d", i + 1), 64'(DataOut), 64'(l_dout[i]));
      if (i == 0) begin
        RdSel = 4'd0;
        check("lat_tap0_data", 64'(TapData), 64'hA5A5A5A5);
        check("lat_tap0_valid", 64'(TapValid), 64'd1);
      end
    end

    // Stream with a stall on edge 3; the stalled word is lost and re-sent
    for (int i = 0; i < 6; i++) begin
      WE = s_we[i]; Stall = s_stall[i]; DataIn = s_din[i];
      tick();
      check($sformatf("str_count_e%0d", i + 1), 64'(Count), 64'(s_cnt[i]));
      check($sformatf("str_valid_e%0d", i + 1), 64'(ValidOut), 64'(s_vld[i]));
      check($sformatf("str_dout_e%0d", i + 1), 64'(DataOut), 64'(s_dout[i]));
    end
    Stall = 1'b0; WE = 1'b0;
    for (int r = 0; r < 4; r++) begin
      RdSel = 4'(r);
      #1;
      check($sformatf("full_tap%0d_data", r), 64'(TapData), 64'(tap_exp[r]));
      check($sformatf("full_tap%0d_valid", r), 64'(TapValid), 64'd1);
    end
    RdSel = 4'd5;
    #1;
    check("tap_oor_data", 64'(TapData), 64'd0);
    check("tap_oor_valid", 64'(TapValid), 64'd0);

    // Flush with WE on a full pipe: flush wins
    Flush = 1'b1; WE = 1'b1; DataIn = 32'h99;
    tick();
    Flush = 1'b0; WE = 1'b0;
    check("flush_count", 64'(Count), 64'd0);
    check("flush_valid", 64'(ValidOut), 64'd0);
    for (int r = 0; r < 4; r++) begin
      RdSel = 4'(r);
      #1;
      check($sformatf("flush_tap%0d_valid", r), 64'(TapValid), 64'd0);
      check($sformatf("flush_tap%0d_data", r), 64'(TapData), 64'd0);
    end

    // Refill, then reset with Stall high: reset wins
    for (int i = 0; i < 4; i++) begin
      WE = 1'b1; DataIn = 32'h10 + 32'(i);
      tick();
    end
    check("refill_count", 64'(Count), 64'd4);
    check("refill_dout", 64'(DataOut), 64'h10);
    RST = 1'b0; Stall = 1'b1; WE = 1'b1; DataIn = 32'h77;
    tick();
    check("rst_mid_count", 64'(Count), 64'd0);
    check("rst_mid_valid", 64'(ValidOut), 64'd0);
    check("rst_mid_dout", 64'(DataOut), 64'd0);
    RdSel = 4'd0;
    #1;
    check("rst_mid_tap0", 64'(TapData), 64'd0);
    RST = 1'b1; Stall = 1'b0; WE = 1'b1; DataIn = 32'hDEAD;
    tick();
    WE = 1'b0;
    check("post_rst_tap0_data", 64'(TapData), 64'hDEAD);
    check("post_rst_tap0_valid", 64'(TapValid), 64'd1);
    check("post_rst_count", 64'(Count), 64'd1);

    // DEPTH=1 instance: single temp register with valid flag
    RST = 1'b0;
    tick();
    RST = 1'b1; WE = 1'b1; DataIn = 32'h12345678; RdSel1 = 1'b0;
    tick();
    check("d1_dout", 64'(DataOut1), 64'h12345678);
    check("d1_valid", 64'(ValidOut1), 64'd1);
    check("d1_count", 64'(Count1), 64'd1);
    check("d1_tap0", 64'(TapData1), 64'h12345678);
    RdSel1 = 1'b1;
    #1;
    check("d1_tap_oor", 64'(TapValid1), 64'd0);
    WE = 1'b0;
    tick();
    check("d1_bubble_valid", 64'(ValidOut1), 64'd0);
    check("d1_bubble_dout", 64'(DataOut1), 64'd0);
    check("d1_bubble_count", 64'(Count1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
